// File: rtl/core_wbu_pkg.sv
// Shared constants for the write-back unit: FSM encodings, source indices/priority, helpers.
package core_wbu_pkg;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  // Source indices double as priority: lower index wins.
  localparam int NUM_SRC    = 5;
  localparam int SRC_ALU    = 0;
  localparam int SRC_IMME   = 1;
  localparam int SRC_PC     = 2;
  localparam int SRC_PC_SEQ = 3;
  localparam int SRC_CSR    = 4;

  localparam logic [63:0] ZERO_WORD = 64'd0;

  function automatic logic multi_hot(input logic [NUM_SRC-1:0] f);
    return |(f & (f - NUM_SRC'(1)));
  endfunction

endpackage

// File: rtl/core_wbu_if.sv
// EXU -> WBU result link: valid/ready handshake plus the result packet fields.
interface core_wbu_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
);
  logic             valid;
  logic             ready;
  logic [XLEN-1:0]  exu_res;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  imme;
  logic             alu_valid;
  logic             imme_valid;
  logic             pc_valid;
  logic             pc_seq_valid;
  logic             csr_valid;
  logic [IDX_W-1:0] rd_idx;

  modport master (
    output valid, exu_res, pc, pc_seq, imme,
           alu_valid, imme_valid, pc_valid, pc_seq_valid, csr_valid, rd_idx,
    input  ready
  );

  modport slave (
    input  valid, exu_res, pc, pc_seq, imme,
           alu_valid, imme_valid, pc_valid, pc_seq_valid, csr_valid, rd_idx,
    output ready
  );
endinterface

// File: rtl/core_wbu_wdata_mux.sv
// Fixed-priority write-data select over the result sources, plus any/multi-hot flag detect.
module core_wbu_wdata_mux
  import core_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [NUM_SRC-1:0]           flags,
  input  logic [NUM_SRC-1:0][XLEN-1:0] src,
  output logic [XLEN-1:0]              wdata,
  output logic                         any,
  output logic                         multi
);

  // Walk from lowest to highest priority so the highest-priority set flag lands last.
  always_comb begin
    wdata = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (flags[i]) wdata = src[i];
    end
  end

  assign any   = |flags;
  assign multi = multi_hot(flags);

endmodule

// File: rtl/core_wbu_top.sv
// Write-back unit: one-entry holding register between EXU and the GPR write port.
// Optional retired-instruction counter built when WBU_INSTRET_EN is defined.
module core_wbu_top
  import core_wbu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  core_wbu_if.slave        wbu_rx,
  input  logic [XLEN-1:0]  csr_rdata,
  output logic             gpr_wen,
  output logic [IDX_W-1:0] gpr_waddr,
  output logic [XLEN-1:0]  gpr_wdata,
  input  logic             gpr_wready,
  output logic             wbu_commit,
  output logic             wbu_err_multi,
  output logic [63:0]      wbu_instret
);

  typedef struct packed {
    logic             need_wr;
    logic [IDX_W-1:0] waddr;
    logic [XLEN-1:0]  wdata;
  } hold_t;

  logic [0:0]                   state;
  hold_t                        hold;
  hold_t                        hold_nxt;
  logic [NUM_SRC-1:0]           flags;
  logic [NUM_SRC-1:0][XLEN-1:0] src;
  logic [XLEN-1:0]              sel_data;
  logic                         src_any;
  logic                         src_multi;
  logic                         accept;
  logic                         retire;

  always_comb begin
    flags             = '0;
    flags[SRC_ALU]    = wbu_rx.alu_valid;
    flags[SRC_IMME]   = wbu_rx.imme_valid;
    flags[SRC_PC]     = wbu_rx.pc_valid;
    flags[SRC_PC_SEQ] = wbu_rx.pc_seq_valid;
    flags[SRC_CSR]    = wbu_rx.csr_valid;
    src               = '0;
    src[SRC_ALU]      = wbu_rx.exu_res;
    src[SRC_IMME]     = wbu_rx.imme;
    src[SRC_PC]       = wbu_rx.pc;
    src[SRC_PC_SEQ]   = wbu_rx.pc_seq;
    src[SRC_CSR]      = csr_rdata;
  end

  core_wbu_wdata_mux #(.XLEN(XLEN)) u_wdata_mux (
    .flags (flags),
    .src   (src),
    .wdata (sel_data),
    .any   (src_any),
    .multi (src_multi)
  );

  // x0 writes are squashed at capture so the port never sees them.
  always_comb begin
    hold_nxt.need_wr = src_any && (wbu_rx.rd_idx != '0);
    hold_nxt.waddr   = wbu_rx.rd_idx;
    hold_nxt.wdata   = sel_data;
  end

  // Ready looks through a retiring entry so back-to-back packets stream at full rate.
  assign retire       = (state == S_FULL) && (!hold.need_wr || gpr_wready);
  assign wbu_rx.ready = (state == S_EMPTY) || retire;
  assign accept       = wbu_rx.valid && wbu_rx.ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_EMPTY;
      hold          <= '0;
      wbu_commit    <= 1'b0;
      wbu_err_multi <= 1'b0;
    end else begin
      wbu_commit <= retire;
      if (accept) begin
        state <= S_FULL;
        hold  <= hold_nxt;
        if (src_multi) wbu_err_multi <= 1'b1;
      end else if (retire) begin
        state <= S_EMPTY;
      end
    end
  end

  assign gpr_wen   = (state == S_FULL) && hold.need_wr;
  assign gpr_waddr = hold.waddr;
  assign gpr_wdata = hold.wdata;

`ifdef WBU_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 64'd1;
  end

  assign wbu_instret = instret_q;
`else
  assign wbu_instret = ZERO_WORD;
`endif

endmodule

// File: tb/tb_core_wbu_top.sv
// Scoreboard bench for core_wbu_top: randomized and directed packets, reference model in the bench.
module tb_core_wbu_top;

  logic        clk;
  logic        rstn;
  logic [31:0] csr_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        gpr_wready;
  logic        wbu_commit;
  logic        wbu_err_multi;
  logic [63:0] wbu_instret;

  core_wbu_if #(.XLEN(32), .IDX_W(5)) rx ();

  core_wbu_top #(.XLEN(32), .IDX_W(5)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .wbu_rx        (rx.slave),
    .csr_rdata     (csr_rdata),
    .gpr_wen       (gpr_wen),
    .gpr_waddr     (gpr_waddr),
    .gpr_wdata     (gpr_wdata),
    .gpr_wready    (gpr_wready),
    .wbu_commit    (wbu_commit),
    .wbu_err_multi (wbu_err_multi),
    .wbu_instret   (wbu_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   commits = 0;
  int   run = 0;
  int   last_run = 0;
  int   nrdy = 0;
  logic err_exp = 1'b0;
  logic streaming = 1'b0;
  logic rand_wr = 1'b0;
  logic        prev_write = 1'b0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: first set flag in order alu, imme, pc, pc_seq, csr supplies the data.
  function automatic logic [31:0] pick(input logic [4:0] fl, input logic [31:0] alu,
                                       input logic [31:0] imm, input logic [31:0] pc,
                                       input logic [31:0] pcs, input logic [31:0] csr);
    if (fl[0]) return alu;
    if (fl[1]) return imm;
    if (fl[2]) return pc;
    if (fl[3]) return pcs;
    if (fl[4]) return csr;
    return 32'd0;
  endfunction

  function automatic int popcnt(input logic [4:0] fl);
    int n = 0;
    for (int i = 0; i < 5; i++) n += int'(fl[i]);
    return n;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [4:0] fl, input logic [4:0] rd, input logic [31:0] alu,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] pcs,
                      input logic [31:0] csr);
    logic acc;
    int   n;
    wr_t  w;
    rx.valid = 1'b1;
    rx.alu_valid = fl[0]; rx.imme_valid = fl[1]; rx.pc_valid = fl[2];
    rx.pc_seq_valid = fl[3]; rx.csr_valid = fl[4];
    rx.exu_res = alu; rx.imme = imm; rx.pc = pc; rx.pc_seq = pcs; csr_rdata = csr;
    rx.rd_idx = rd;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rx.ready;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout act=notaccepted exp=accepted");
    end else begin
      accepted++;
      if (popcnt(fl) > 1) err_exp = 1'b1;
      if (fl != 5'd0 && rd != 5'd0) begin
        w.addr = rd;
        w.data = pick(fl, alu, imm, pc, pcs, csr);
        exp_q.push_back(w);
      end
    end
    #1;
    rx.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || commits != accepted) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_commits", 64'(commits), 64'(accepted));
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_instret(input string nm);
`ifdef WBU_INSTRET_EN
    chk(nm, wbu_instret, 64'(accepted));
`else
    chk(nm, wbu_instret, 64'd0);
`endif
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_wr) gpr_wready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every completed write and checks port protocol.
  always @(negedge clk) begin
    wr_t e;
    if (!rstn) begin
      commits = 0; run = 0; last_run = 0;
      prev_write = 1'b0; prev_stall = 1'b0;
    end else begin
      if (prev_write) chk("commit_after_write", 64'(wbu_commit), 64'd1);
      if (prev_stall) begin
        chk("stall_wen_held", 64'(gpr_wen), 64'd1);
        chk("stall_waddr_stable", 64'(gpr_waddr), 64'(prev_addr));
        chk("stall_wdata_stable", 64'(gpr_wdata), 64'(prev_data));
      end
      if (gpr_wen && !gpr_wready) chk("stall_rx_ready", 64'(rx.ready), 64'd0);
      if (streaming && !rx.ready) nrdy++;
      if (wbu_commit) commits++;
      chk("err_multi", 64'(wbu_err_multi), 64'(err_exp));
      if (gpr_wen && gpr_wready) begin
        run++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write act=addr%0d/data%0h exp=nowrite", gpr_waddr, gpr_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(gpr_waddr), 64'(e.addr));
          chk("wr_data", 64'(gpr_wdata), 64'(e.data));
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      prev_write = gpr_wen && gpr_wready;
      prev_stall = gpr_wen && !gpr_wready;
      prev_addr  = gpr_waddr;
      prev_data  = gpr_wdata;
    end
  end

  initial begin
    logic [4:0] fl;
    int r;
    rstn = 1'b0;
    gpr_wready = 1'b1;
    csr_rdata = '0;
    rx.valid = 1'b0; rx.exu_res = '0; rx.pc = '0; rx.pc_seq = '0; rx.imme = '0;
    rx.alu_valid = 1'b0; rx.imme_valid = 1'b0; rx.pc_valid = 1'b0;
    rx.pc_seq_valid = 1'b0; rx.csr_valid = 1'b0; rx.rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", 64'(rx.ready), 64'd1);
    chk("rst_wen", 64'(gpr_wen), 64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_commit", 64'(wbu_commit), 64'd0);
    chk("rst_err", 64'(wbu_err_multi), 64'd0);
    chk("rst_instret", wbu_instret, 64'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // ALU write, one-cycle latency to wen
    send(5'b00001, 5'd5, 32'h1234, 32'h1, 32'h2, 32'h3, 32'h4);
    @(negedge clk);
    chk("alu_lat_wen", 64'(gpr_wen), 64'd1);
    chk("alu_lat_waddr", 64'(gpr_waddr), 64'd5);
    chk("alu_lat_wdata", 64'(gpr_wdata), 64'h1234);
    @(posedge clk); #1;
    drain();
    chk_instret("alu_instret");

    // x0 destination and no-source packets retire without writing
    send(5'b00001, 5'd0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0);
    send(5'b00000, 5'd7, 32'hAAAA, 32'h0, 32'h0, 32'h0, 32'h0);
    drain();
    chk_instret("nowr_instret");

    // Back-pressure on the GPR port
    gpr_wready = 1'b0;
    send(5'b00010, 5'd3, 32'h0, 32'hABCDE000, 32'h0, 32'h0, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_wen", 64'(gpr_wen), 64'd1);
      chk("bp_rx_ready", 64'(rx.ready), 64'd0);
      @(posedge clk); #1;
    end
    gpr_wready = 1'b1;
    @(negedge clk);
    chk("bp_release_wen", 64'(gpr_wen), 64'd1);
    @(posedge clk); #1;
    drain();
    chk_instret("bp_instret");

    // Streaming at full rate
    nrdy = 0;
    streaming = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fl = 5'b00001 << $urandom_range(0, 4);
      send(fl, 5'(i + 1), $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    streaming = 1'b0;
    drain();
    chk("stream_rx_ready_drops", 64'(nrdy), 64'd0);
    chk("stream_consecutive_writes", 64'(last_run), 64'd8);
    chk_instret("stream_instret");

    // Multi-hot flags: alu wins, sticky error
    send(5'b01001, 5'd6, 32'h10, 32'h0, 32'h0, 32'h84, 32'h0);
    drain();
    chk("multi_err_set", 64'(wbu_err_multi), 64'd1);

    // Randomized traffic with random GPR back-pressure
    rand_wr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      r = $urandom_range(0, 9);
      if (r < 2)      fl = 5'b00000;
      else if (r < 3) fl = 5'($urandom_range(0, 31));
      else            fl = 5'b00001 << $urandom_range(0, 4);
      send(fl, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    rand_wr = 1'b0;
    gpr_wready = 1'b1;
    drain();
    chk_instret("rand_instret");

    // Reset while a write is stalled
    gpr_wready = 1'b0;
    send(5'b00001, 5'd9, 32'hDEAD, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid_pre_wen", 64'(gpr_wen), 64'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_q.delete();
    accepted = 0;
    err_exp = 1'b0;
    #2;
    chk("mid_rst_wen", 64'(gpr_wen), 64'd0);
    chk("mid_rst_rx_ready", 64'(rx.ready), 64'd1);
    chk("mid_rst_commit", 64'(wbu_commit), 64'd0);
    chk("mid_rst_err", 64'(wbu_err_multi), 64'd0);
    chk("mid_rst_instret", wbu_instret, 64'd0);
    @(posedge clk); #3;
    rstn = 1'b1;
    gpr_wready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_commit", 64'(wbu_commit), 64'd0);
      chk("post_rst_wen", 64'(gpr_wen), 64'd0);
    end
    @(posedge clk); #1;
    chk_instret("post_rst_instret0");
    send(5'b00100, 5'd12, 32'h0, 32'h0, 32'h8000_0010, 32'h0, 32'h0);
    drain();
    chk_instret("post_rst_instret1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
